multi_cycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the MIPS-subset datapath (PC, IR, regfile, ALU, data memory).

---
 rtl/multi_cycle_ctrl.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//   Multi-cycle control FSM for a MIPS-subset datapath. It steps each
//   instruction through IF / ID / EXE / MEM / WB and drives every datapath
//   write enable and mux select. Only the state register and the sticky halt
//   flag are stored. All other outputs are decoded combinationally from
//   (state, op, zero, halted), and the write enables are also gated by Reset.
//
// Configuration macro:
//   CTRL_MEM_WAIT_EN  when defined, adds the mem_ready input. MEM then holds
//                     until data memory reports completion. When undefined,
//                     MEM always lasts exactly one cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   Reset      in   asynchronous, active-high reset
//   op[5:0]    in   opcode from IR (valid from ID onward)
//   zero       in   ALU zero flag (used in EXE_B)
//   mem_ready  in   data memory done (CTRL_MEM_WAIT_EN builds only)
//   state[2:0] out  current FSM state
//   PCWre, IRWre, RegWre, mRD, mWR        out  write / memory enables
//   ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc,
//   ExtSel, RegDst[1:0], PCSrc[1:0]       out  datapath selects
//   ALUOp[2:0] out  ALU function
//   halted     out  sticky halt flag, cleared only by Reset
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
  parameter int unsigned STATE_W = 3,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [5:0]         op,
  input  logic               zero,
`ifdef CTRL_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic [STATE_W-1:0] state,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic               mRD,
  output logic               mWR,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               DBDataSrc,
  output logic               WrRegDSrc,
  output logic               ExtSel,
  output logic [1:0]         RegDst,
  output logic [1:0]         PCSrc,
  output logic [2:0]         ALUOp,
  output logic               halted
);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] DST_RA = 2'b00;
  localparam logic [1:0] DST_RT = 2'b01;
  localparam logic [1:0] DST_RD = 2'b10;

  // The encoding is fixed because the state code is visible on the port.
  typedef enum logic [STATE_W-1:0] {
    S_IF    = 3'b000,
    S_ID    = 3'b001,
    S_EXE_A = 3'b110,
    S_EXE_B = 3'b101,
    S_EXE_M = 3'b010,
    S_MEM   = 3'b011,
    S_WB_A  = 3'b111,
    S_WB_M  = 3'b100
  } state_t;

  state_t     state_q, state_d;
  logic       halted_q, halted_d;

  logic       is_r_type;
  logic       is_imm;
  logic       is_arith;
  logic [2:0] arith_aluop;
  logic       mem_done;

`ifdef CTRL_MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  // Opcode class decode shared by the ID dispatch and the arithmetic states.
  assign is_r_type = op inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT};
  assign is_imm    = op inside {OP_ADDI, OP_ORI};
  assign is_arith  = is_r_type | is_imm;

  always_comb begin
    case (op)
      OP_SUB:         arith_aluop = ALU_SUB;
      OP_OR, OP_ORI:  arith_aluop = ALU_OR;
      OP_AND:         arith_aluop = ALU_AND;
      OP_SLT:         arith_aluop = ALU_SLT;
      default:        arith_aluop = ALU_ADD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IF;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no
    // path through the case statement can leave a value unassigned. This
    // prevents latch inference and gives don't-care outputs a value of 0.
    state_d   = state_q;
    halted_d  = halted_q;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b0;
    ExtSel    = 1'b0;
    RegDst    = DST_RA;
    PCSrc     = PC_NEXT;
    ALUOp     = ALU_ADD;

    case (state_q)
      S_IF: begin
        // When halted, the FSM stays in IF with IRWre low, so the machine
        // is frozen.
        if (!halted_q) begin
          IRWre   = 1'b1;
          state_d = S_ID;
        end
      end

      S_ID: begin
        if (op == HALT_OP) begin
          halted_d = 1'b1;
          state_d  = S_IF;
        end else if (is_arith) begin
          state_d = S_EXE_A;
        end else begin
          case (op)
            OP_BEQ, OP_BNE: state_d = S_EXE_B;
            OP_LW, OP_SW:   state_d = S_EXE_M;
            OP_J: begin
              PCWre   = 1'b1;
              PCSrc   = PC_JUMP;
              state_d = S_IF;
            end
            OP_JR: begin
              PCWre   = 1'b1;
              PCSrc   = PC_RS;
              state_d = S_IF;
            end
            OP_JAL: begin
              // The link write ($31 <= PC+4) happens in the same cycle as
              // the jump.
              PCWre     = 1'b1;
              PCSrc     = PC_JUMP;
              RegWre    = 1'b1;
              RegDst    = DST_RA;
              WrRegDSrc = 1'b0;
              state_d   = S_IF;
            end
            default: begin
              // An unknown opcode executes as a NOP and just advances the PC.
              PCWre   = 1'b1;
              PCSrc   = PC_NEXT;
              state_d = S_IF;
            end
          endcase
        end
      end

      S_EXE_A, S_WB_A: begin
        // Arithmetic selects stay stable for both cycles, so the ALU
        // result is still valid when the register file writes it.
        ALUOp     = arith_aluop;
        ALUSrcB   = is_imm;
        ExtSel    = (op != OP_ORI);
        RegDst    = is_imm ? DST_RT : DST_RD;
        WrRegDSrc = 1'b1;
        if (state_q == S_EXE_A) begin
          state_d = S_WB_A;
        end else begin
          RegWre  = 1'b1;
          PCWre   = 1'b1;
          state_d = S_IF;
        end
      end

      S_EXE_B: begin
        ALUOp = ALU_SUB;
        PCWre = 1'b1;
        if (((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero)) begin
          PCSrc = PC_BRANCH;
        end
        state_d = S_IF;
      end

      S_EXE_M: begin
        ALUOp   = ALU_ADD;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        state_d = S_MEM;
      end

      S_MEM: begin
        // The memory strobe stays asserted while waiting. PC and register
        // writes wait until the access completes.
        if (op == OP_LW) begin
          mRD = 1'b1;
          if (mem_done) state_d = S_WB_M;
        end else begin
          mWR = 1'b1;
          if (mem_done) begin
            PCWre   = 1'b1;
            state_d = S_IF;
          end
        end
      end

      S_WB_M: begin
        RegWre    = 1'b1;
        RegDst    = DST_RT;
        DBDataSrc = 1'b1;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
        state_d   = S_IF;
      end

      default: state_d = S_IF;
    endcase

    // Reset aborts immediately. No enable may pulse during the cycle in
    // which Reset rises.
    if (Reset) begin
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      mRD    = 1'b0;
      mWR    = 1'b0;
    end
  end

  assign state  = state_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//   Self-checking bench for multi_cycle_ctrl. It covers:
//     - a directed vector table;
//     - randomized instruction streams checked against a per-instruction
//       behavioural model;
//     - hand-written reset-abort, halt and (with CTRL_MEM_WAIT_EN) memory
//       wait sequences.
//   Inputs change and outputs are sampled in the low phase of the clock.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

  localparam logic [5:0] ADD  = 6'b000000;
  localparam logic [5:0] SUB  = 6'b000001;
  localparam logic [5:0] ADDI = 6'b000010;
  localparam logic [5:0] OR_  = 6'b010000;
  localparam logic [5:0] AND_ = 6'b010001;
  localparam logic [5:0] ORI  = 6'b010010;
  localparam logic [5:0] SLT  = 6'b100110;
  localparam logic [5:0] SW   = 6'b110000;
  localparam logic [5:0] LW   = 6'b110001;
  localparam logic [5:0] BEQ  = 6'b110100;
  localparam logic [5:0] BNE  = 6'b110101;
  localparam logic [5:0] J    = 6'b111000;
  localparam logic [5:0] JR   = 6'b111001;
  localparam logic [5:0] JAL  = 6'b111010;
  localparam logic [5:0] HALT = 6'b111111;
  localparam logic [5:0] BAD  = 6'b000011;

  logic       clk = 1'b0;
  logic       Reset;
  logic [5:0] op;
  logic       zero;
`ifdef CTRL_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic [2:0] state;
  logic       PCWre, IRWre, RegWre, mRD, mWR;
  logic       ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;
  logic       halted;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk       (clk),
    .Reset     (Reset),
    .op        (op),
    .zero      (zero),
`ifdef CTRL_MEM_WAIT_EN
    .mem_ready (mem_ready),
`endif
    .state     (state),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .RegWre    (RegWre),
    .mRD       (mRD),
    .mWR       (mWR),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .DBDataSrc (DBDataSrc),
    .WrRegDSrc (WrRegDSrc),
    .ExtSel    (ExtSel),
    .RegDst    (RegDst),
    .PCSrc     (PCSrc),
    .ALUOp     (ALUOp),
    .halted    (halted)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre, irwre, regwre, mrd, mwr;
    logic       alusrca, alusrcb, dbdatasrc, wrregdsrc, extsel;
    logic [1:0] regdst, pcsrc;
    logic [2:0] aluop;
    logic       halted;
  } outs_t;

  typedef struct packed {
    logic [5:0] op;
    logic       zero;
    outs_t      exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t s;
    s.st = state;
    s.pcwre = PCWre;  s.irwre = IRWre;  s.regwre = RegWre;
    s.mrd = mRD;      s.mwr = mWR;
    s.alusrca = ALUSrcA; s.alusrcb = ALUSrcB; s.dbdatasrc = DBDataSrc;
    s.wrregdsrc = WrRegDSrc; s.extsel = ExtSel;
    s.regdst = RegDst; s.pcsrc = PCSrc; s.aluop = ALUOp; s.halted = halted;
    return s;
  endfunction

  // ---------------- behavioural reference model ----------------
  function automatic bit is_imm_op(input logic [5:0] o);
    return (o == ADDI) || (o == ORI);
  endfunction

  function automatic bit is_arith_op(input logic [5:0] o);
    return is_imm_op(o) || (o == ADD) || (o == SUB) || (o == OR_) ||
           (o == AND_) || (o == SLT);
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] o);
    if (o == SUB) return 3'b001;
    if (o == OR_ || o == ORI) return 3'b010;
    if (o == AND_) return 3'b011;
    if (o == SLT) return 3'b100;
    return 3'b000;
  endfunction

  // Total cycles an instruction occupies (no memory wait).
  function automatic int seq_len(input logic [5:0] o);
    if (is_arith_op(o) || o == SW) return 4;
    if (o == LW) return 5;
    if (o == BEQ || o == BNE) return 3;
    return 2;
  endfunction

  // Expected outputs in cycle k (0 = fetch) of instruction o.
  function automatic outs_t exp_out(input logic [5:0] o, input logic z, input int k);
    outs_t e;
    int n;
    e = '0;
    n = seq_len(o);
    if (k == 0) begin
      e.irwre = 1'b1;
      return e;
    end
    if (k == 1) e.st = 3'b001;
    if (k == n - 1 && o != HALT) e.pcwre = 1'b1;
    if (is_arith_op(o) && k >= 2) begin
      e.st        = (k == 2) ? 3'b110 : 3'b111;
      e.aluop     = alu_of(o);
      e.alusrcb   = is_imm_op(o);
      e.extsel    = (o != ORI);
      e.regdst    = is_imm_op(o) ? 2'b01 : 2'b10;
      e.wrregdsrc = 1'b1;
      e.regwre    = (k == 3);
    end else if ((o == BEQ || o == BNE) && k == 2) begin
      e.st    = 3'b101;
      e.aluop = 3'b001;
      if ((o == BEQ && z) || (o == BNE && !z)) e.pcsrc = 2'b01;
    end else if ((o == LW || o == SW) && k >= 2) begin
      if (k == 2) begin
        e.st = 3'b010; e.alusrcb = 1'b1; e.extsel = 1'b1;
      end else if (k == 3) begin
        e.st = 3'b011; e.mrd = (o == LW); e.mwr = (o == SW);
      end else begin
        e.st = 3'b100; e.regwre = 1'b1; e.regdst = 2'b01;
        e.dbdatasrc = 1'b1; e.wrregdsrc = 1'b1;
      end
    end else if (k == 1 && (o == J || o == JR || o == JAL)) begin
      e.pcsrc = (o == JR) ? 2'b10 : 2'b11;
      if (o == JAL) e.regwre = 1'b1;
    end
    return e;
  endfunction

  // Directed vector: en = {PCWre,IRWre,RegWre,mRD,mWR}, sel = {ALUSrcB,DBDataSrc,WrRegDSrc,ExtSel}.
  task automatic add_vec(input logic [5:0] o, input logic z, input logic [2:0] st,
                         input logic [4:0] en, input logic [1:0] rd, input logic [1:0] ps,
                         input logic [2:0] al, input logic [3:0] sel);
    vec_t v;
    v.op = o;
    v.zero = z;
    v.exp = '0;
    v.exp.st = st;
    {v.exp.pcwre, v.exp.irwre, v.exp.regwre, v.exp.mrd, v.exp.mwr} = en;
    {v.exp.alusrcb, v.exp.dbdatasrc, v.exp.wrregdsrc, v.exp.extsel} = sel;
    v.exp.regdst = rd;
    v.exp.pcsrc = ps;
    v.exp.aluop = al;
    vecs.push_back(v);
  endtask

  // Drive inputs in the low phase, sample 1 ns later, then move to the next negedge.
  task automatic apply(input string name, input logic [5:0] o, input logic z, input outs_t e);
    op = o;
    zero = z;
    #1;
    check(name, 32'(sample()), 32'(e));
    @(negedge clk);
  endtask

  task automatic run_instr(input string tag, input logic [5:0] o);
    logic z;
    for (int k = 0; k < seq_len(o); k++) begin
      z = 1'($urandom_range(0, 1));
      apply($sformatf("%s_k%0d", tag, k), o, z, exp_out(o, z, k));
    end
  endtask

  logic [5:0] pool [15];
  outs_t      e_frozen;
  outs_t      e_tmp;
  logic [5:0] o_rnd;
  logic       z_rnd;

  initial begin
    pool = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLT, SW, LW, BEQ, BNE, J, JR, JAL, BAD};
    e_frozen = '0;
    e_frozen.halted = 1'b1;

    // ADD, LW, BEQ z=1, BNE z=1, JAL, ORI.
    add_vec(ADD, 0, 3'b000, 5'b01000, 2'b00, 2'b00, 3'b000, 4'b0000);
    add_vec(ADD, 0, 3'b001, 5'b00000, 2'b00, 2'b00, 3'b000, 4'b0000);
    add_vec(ADD, 0, 3'b110, 5'b00000, 2'b10, 2'b00, 3'b000, 4'b0011);
    add_vec(ADD, 0, 3'b111, 5'b10100, 2'b10, 2'b00, 3'b000, 4'b0011);
    add_vec(LW,  0, 3'b000, 5'b01000, 2'b00, 2'b00, 3'b000, 4'b0000);
    add_vec(LW,  0, 3'b001, 5'b00000, 2'b00, 2'b00, 3'b000, 4'b0000);
    add_vec(LW,  0, 3'b010, 5'b00000, 2'b00, 2'b00, 3'b000, 4'b1001);
    add_vec(LW,  0, 3'b011, 5'b00010, 2'b00, 2'b00, 3'b000, 4'b0000);
    add_vec(LW,  0, 3'b100, 5'b10100, 2'b01, 2'b00, 3'b000, 4'b0110);
    add_vec(BEQ, 1, 3'b000, 5'b01000, 2'b00, 2'b00, 3'b000, 4'b0000);
    add_vec(BEQ, 1, 3'b001, 5'b00000, 2'b00, 2'b00, 3'b000, 4'b0000);
    add_vec(BEQ, 1, 3'b101, 5'b10000, 2'b00, 2'b01, 3'b001, 4'b0000);
    add_vec(BNE, 1, 3'b000, 5'b01000, 2'b00, 2'b00, 3'b000, 4'b0000);
    add_vec(BNE, 1, 3'b001, 5'b00000, 2'b00, 2'b00, 3'b000, 4'b0000);
    add_vec(BNE, 1, 3'b101, 5'b10000, 2'b00, 2'b00, 3'b001, 4'b0000);
    add_vec(JAL, 0, 3'b000, 5'b01000, 2'b00, 2'b00, 3'b000, 4'b0000);
    add_vec(JAL, 0, 3'b001, 5'b10100, 2'b00, 2'b11, 3'b000, 4'b0000);
    add_vec(ORI, 0, 3'b000, 5'b01000, 2'b00, 2'b00, 3'b000, 4'b0000);
    add_vec(ORI, 0, 3'b001, 5'b00000, 2'b00, 2'b00, 3'b000, 4'b0000);
    add_vec(ORI, 0, 3'b110, 5'b00000, 2'b01, 2'b00, 3'b010, 4'b1010);
    add_vec(ORI, 0, 3'b111, 5'b10100, 2'b01, 2'b00, 3'b010, 4'b1010);

    Reset = 1'b1;
    op    = ADD;
    zero  = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    @(negedge clk);
    #1;
    // While Reset is held: IF, not halted, every enable low.
    check("reset_state", 32'(sample()), 32'(outs_t'('0)));
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].zero, vecs[i].exp);

    // Randomized instruction stream; the opcode seen during fetch is garbage.
    for (int t = 0; t < 150; t++) begin
      o_rnd = pool[$urandom_range(0, 14)];
      for (int k = 0; k < seq_len(o_rnd); k++) begin
        z_rnd = 1'($urandom_range(0, 1));
        apply($sformatf("rnd%0d_k%0d", t, k), (k == 0) ? 6'($urandom) : o_rnd,
              z_rnd, exp_out(o_rnd, z_rnd, k));
      end
    end

    // Reset pulse in the middle of EXE_A aborts the ADD with no writes.
    apply("rst_if", ADD, 0, exp_out(ADD, 0, 0));
    apply("rst_id", ADD, 0, exp_out(ADD, 0, 1));
    op = ADD;
    #1;
    check("rst_pre_exe_a", 32'(sample()), 32'(exp_out(ADD, 0, 2)));
    Reset = 1'b1;
    #1;
    check("rst_abort", 32'(sample()), 32'(outs_t'('0)));
    @(negedge clk);
    #1;
    check("rst_hold", 32'(sample()), 32'(outs_t'('0)));
    Reset = 1'b0;
    run_instr("post_rst_sub", SUB);

    // JAL, then HALT: the machine freezes in IF with all enables low.
    run_instr("jal", JAL);
    apply("halt_if", HALT, 0, exp_out(HALT, 0, 0));
    apply("halt_id", HALT, 0, exp_out(HALT, 0, 1));
    for (int c = 0; c < 20; c++)
      apply($sformatf("halt_frozen%0d", c), pool[$urandom_range(0, 14)],
            1'($urandom_range(0, 1)), e_frozen);
    Reset = 1'b1;
    #1;
    check("halt_reset_clear", 32'(sample()), 32'(outs_t'('0)));
    Reset = 1'b0;
    run_instr("post_halt_lw", LW);

`ifdef CTRL_MEM_WAIT_EN
    // SW with mem_ready low for 3 cycles holds MEM for 4 cycles.
    for (int k = 0; k < 3; k++)
      apply($sformatf("sw_wait_k%0d", k), SW, 0, exp_out(SW, 0, k));
    mem_ready = 1'b0;
    e_tmp = exp_out(SW, 0, 3);
    e_tmp.pcwre = 1'b0;
    for (int c = 0; c < 3; c++)
      apply($sformatf("sw_mem_hold%0d", c), SW, 0, e_tmp);
    mem_ready = 1'b1;
    apply("sw_mem_done", SW, 0, exp_out(SW, 0, 3));
    apply("sw_back_if", SW, 0, exp_out(SW, 0, 0));
    // LW waits two cycles in MEM with mRD held, then writes back.
    apply("lw_wait_id", LW, 0, exp_out(LW, 0, 1));
    apply("lw_wait_exe", LW, 0, exp_out(LW, 0, 2));
    mem_ready = 1'b0;
    for (int c = 0; c < 2; c++)
      apply($sformatf("lw_mem_hold%0d", c), LW, 0, exp_out(LW, 0, 3));
    mem_ready = 1'b1;
    apply("lw_mem_done", LW, 0, exp_out(LW, 0, 3));
    apply("lw_wb", LW, 0, exp_out(LW, 0, 4));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
